// File: rtl/spi_master_io.sv
// spi_master_io: byte-oriented SPI master, mode 0 (cpol=0, cpha=0), with a
// one-entry transmit holding buffer and selectable bit order.
module spi_master_io (
    input  logic       sclk,
    input  logic       nreset,
    input  logic       spi_en,
    input  logic [7:0] clkdiv,
    input  logic       lsbfirst,
    input  logic       tx_access,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_wait,
    output logic       rx_access,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       sck,
    output logic       mosi,
    output logic       ss,
    input  logic       miso
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned BIT_W  = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_STALL = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic              sck_q, sck_d;
    logic              ss_q, ss_d;
    logic              mosi_q, mosi_d;
    logic [BYTE_W-1:0] sh_q, sh_d;
    logic [BYTE_W-1:0] rx_sh_q, rx_sh_d;
    logic [BYTE_W-1:0] rx_data_q, rx_data_d;
    logic [BYTE_W-1:0] buf_data_q, buf_data_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              cur_last_q, cur_last_d;
    logic              buf_full_q, buf_full_d;
    logic              buf_last_q, buf_last_d;
    logic              rx_access_q, rx_access_d;
    logic              tx_wait_q, tx_wait_d;
    logic              busy_q, busy_d;

    logic              expire_c;
    logic              accept_c;
    logic              load_c;

    // Half-period expiry and upstream handshake.
    assign expire_c = (cnt_q == div_q);
    assign accept_c = tx_access & ~tx_wait_q & spi_en;

    // Next-state logic: sequencing, shifting, buffer management and abort.
    always_comb begin
        state_d     = state_q;
        cnt_d       = expire_c ? '0 : cnt_q + CNT_W'(1);
        div_d       = div_q;
        sck_d       = sck_q;
        ss_d        = ss_q;
        mosi_d      = mosi_q;
        sh_d        = sh_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        buf_data_d  = buf_data_q;
        bit_d       = bit_q;
        cur_last_d  = cur_last_q;
        buf_full_d  = buf_full_q;
        buf_last_d  = buf_last_q;
        rx_access_d = 1'b0;
        tx_wait_d   = tx_wait_q;
        busy_d      = busy_q;
        load_c      = 1'b0;

        if (accept_c) begin
            buf_full_d = 1'b1;
            buf_data_d = tx_data;
            buf_last_d = tx_last;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (buf_full_q) begin
                    state_d = ST_SETUP;
                    ss_d    = 1'b0;
                    load_c  = 1'b1;
                end
            end
            ST_SETUP: begin
                if (expire_c) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (expire_c) begin
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        rx_sh_d = lsbfirst ? {miso, rx_sh_q[BYTE_W-1:1]}
                                           : {rx_sh_q[BYTE_W-2:0], miso};
                    end else if (bit_q == BIT_W'(BYTE_W - 1)) begin
                        rx_access_d = 1'b1;
                        rx_data_d   = rx_sh_q;
                        if (cur_last_q)      state_d = ST_HOLD;
                        else if (buf_full_q) load_c  = 1'b1;
                        else                 state_d = ST_STALL;
                    end else begin
                        bit_d  = bit_q + BIT_W'(1);
                        sh_d   = lsbfirst ? (sh_q >> 1) : (sh_q << 1);
                        mosi_d = lsbfirst ? sh_q[1] : sh_q[BYTE_W-2];
                    end
                end
            end
            ST_STALL: begin
                // Half-period timer only runs once a byte is waiting.
                if (!buf_full_q) begin
                    cnt_d = '0;
                end else if (expire_c) begin
                    state_d = ST_SHIFT;
                    load_c  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (expire_c) begin
                    ss_d    = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (expire_c) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_c) begin
            sh_d       = buf_data_q;
            cur_last_d = buf_last_q;
            mosi_d     = lsbfirst ? buf_data_q[0] : buf_data_q[BYTE_W-1];
            bit_d      = '0;
            buf_full_d = 1'b0;
        end

        if (state_d != state_q) cnt_d = '0;

        if (!spi_en) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            sck_d       = 1'b0;
            ss_d        = 1'b1;
            mosi_d      = 1'b0;
            bit_d       = '0;
            buf_full_d  = 1'b0;
            rx_access_d = 1'b0;
        end

        // Divider is sampled only when the half-period counter restarts.
        div_d     = (cnt_d == '0) ? clkdiv : div_q;
        tx_wait_d = spi_en ? buf_full_d : 1'b1;
        busy_d    = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge sclk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            div_q       <= '0;
            sck_q       <= 1'b0;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b0;
            sh_q        <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            buf_data_q  <= '0;
            bit_q       <= '0;
            cur_last_q  <= 1'b0;
            buf_full_q  <= 1'b0;
            buf_last_q  <= 1'b0;
            rx_access_q <= 1'b0;
            tx_wait_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            sck_q       <= sck_d;
            ss_q        <= ss_d;
            mosi_q      <= mosi_d;
            sh_q        <= sh_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            buf_data_q  <= buf_data_d;
            bit_q       <= bit_d;
            cur_last_q  <= cur_last_d;
            buf_full_q  <= buf_full_d;
            buf_last_q  <= buf_last_d;
            rx_access_q <= rx_access_d;
            tx_wait_q   <= tx_wait_d;
            busy_q      <= busy_d;
        end
    end

    assign tx_wait   = tx_wait_q;
    assign rx_access = rx_access_q;
    assign rx_data   = rx_data_q;
    assign busy      = busy_q;
    assign sck       = sck_q;
    assign mosi      = mosi_q;
    assign ss        = ss_q;

endmodule
